mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin an operation; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 busA  input  32  operand A, i.e. register-file read port A (multiplicand or dividend).
REQ-007 busB  input  32  operand B, i.e. register-file read port B (multiplier or divisor).
REQ-008 hi_we  input  1  direct HI write (MTHI).
REQ-009 lo_we  input  1  direct LO write (MTLO).
REQ-010 wdata  input  32  data for hi_we and lo_we.
REQ-011 hi  output  32  HI register: product upper word or remainder.
REQ-012 lo  output  32  LO register: product lower word or quotient.
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  one-cycle pulse when HI and LO hold a new result.

Function
REQ-015 The block SHALL use three states, IDLE, CALC and FIX, with all outputs registered.
REQ-016 In IDLE, start=1 at rising edge E0 SHALL latch op, busA and busB, go to CALC, and set busy=1.
REQ-017 CALC SHALL run 32 iterations, one per edge (E1..E32), and SHALL go to FIX at E32.
- Multiply: radix-2 shift-add on operand magnitudes into a 64-bit accumulator.
- Divide: restoring shift-subtract on operand magnitudes.
REQ-018 At E33 FIX SHALL write HI/LO, go to IDLE, set busy=0, and assert done=1 for exactly one cycle.
- Result latency: HI/LO valid 33 cycles after the start edge.
REQ-019 Signed operations SHALL be computed on magnitudes and sign-corrected in FIX.
- Product sign = sign(A) XOR sign(B).
- Quotient truncates toward zero.
- Remainder takes the sign of A.
REQ-020 MULT/MULTU SHALL produce the full 64-bit product: HI = bits 63:32, LO = bits 31:0.
REQ-021 Divide by zero (B=0), signed or unsigned, SHALL take the full 33 cycles and yield HI=A, LO=0xFFFFFFFF.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0 (wrap, no trap).
REQ-023 start, hi_we and lo_we SHALL be ignored while busy=1.
- HI/LO SHALL hold their prior values until FIX.
REQ-024 In IDLE without start, hi_we and lo_we SHALL load wdata into HI and LO respectively at the next edge; both may write in the same cycle.
REQ-025 In IDLE, start SHALL take priority over hi_we and lo_we in the same cycle; the direct writes are dropped.
REQ-026 Operands SHALL be latched at E0; later changes on busA/busB SHALL NOT affect the result.
REQ-027 done SHALL be 0 in every cycle other than the one after FIX.
- A start in the done cycle is accepted normally (back-to-back operation).

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, hi=0, lo=0, busy=0, done=0, and clear all internal accumulators, counters and latched operands.
REQ-029 Reset mid-operation SHALL abort the operation with no done pulse.
- Operation resumes only with a new start after rst_n returns to 1.

Structure
REQ-030 Opcode constants (MULT, MULTU, DIV, DIVU) and the state encodings SHALL reside in the shared CPU package.
REQ-031 The iteration datapath SHALL be one sub-module, mdu_iter_core.
- Contents: 64-bit shift register, adder/subtractor, 6-bit iteration counter.
- The top level holds the FSM, sign logic and the HI/LO registers.

Verification
REQ-032 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> at E33 HI=0xFFFFFFFE, LO=0x00000001, done high one cycle, busy high E1..E32.
REQ-033 MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
REQ-034 DIV A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU A=100, B=0 -> HI=100, LO=0xFFFFFFFF.
REQ-035 Start MULTU 3*4, assert start and hi_we at E10, and change busA at E5 -> both ignored; result HI=0, LO=12.
REQ-036 Start DIVU, pull rst_n low at E15 -> hi=lo=0 and busy=0 immediately; no done pulse; a new DIVU 9/4 then yields LO=2, HI=1.
REQ-037 In IDLE, hi_we=1 with wdata=0x1234 -> hi=0x1234 next cycle; start plus lo_we in the same cycle -> lo_we dropped, operation runs.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared CPU definitions used by the multiply/divide unit.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package mult_div_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    // Signed ops take the magnitude of negative operands; unsigned pass through.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic is_signed);
        return (is_signed && x[XLEN-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative datapath: radix-2 shift-add multiply / restoring shift-subtract divide.
// Latency: one iteration per step cycle, last asserted during the 32nd step.
// Backpressure: none; the controller paces it with load/step.
module mdu_iter_core
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);

    logic [WIDTH-1:0]   opnd;
    logic               div_mode;
    logic [5:0]         cnt;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   sub_diff;

    assign last = (cnt == 6'(WIDTH - 1));

    // One iteration of whichever algorithm is loaded.
    always_comb begin
        // Multiply: add multiplicand to the upper half when the current multiplier bit is set,
        // keep the carry and shift the whole accumulator right.
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Divide: the partial remainder needs one extra bit after the left shift.
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        sub_diff  = {1'b0, rem_shift} - {2'b00, opnd};
        if (!div_mode) begin
            acc_nxt = {add_sum, acc[WIDTH-1:1]};
        end else if (!sub_diff[WIDTH+1]) begin
            acc_nxt = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    // Accumulator, stored operand and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            cnt      <= '0;
        end else if (load) begin
            acc      <= is_div ? {{WIDTH{1'b0}}, opa} : {{WIDTH{1'b0}}, opb};
            opnd     <= is_div ? opb : opa;
            div_mode <= is_div;
            cnt      <= '0;
        end else if (step) begin
            acc      <= acc_nxt;
            cnt      <= cnt + 6'd1;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: FSM, sign correction and architectural HI/LO registers.
// Latency: HI/LO and the done pulse appear 33 cycles after the start edge.
// Backpressure: start and direct HI/LO writes are ignored while busy is high.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    state_t             state, state_nxt;
    op_t                op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   hi_d, lo_d;
    logic               busy_d, done_d;
    logic               load, step, last;
    logic               in_signed;
    logic [2*WIDTH-1:0] acc;
    logic               q_signed, sa, sb;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign load      = (state == ST_IDLE) && start;
    assign step      = (state == ST_CALC);
    assign in_signed = (op_t'(op) == OP_MULT) || (op_t'(op) == OP_DIV);

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .is_div (op[1]),
        .opa    (mag(busA, in_signed)),
        .opb    (mag(busB, in_signed)),
        .acc    (acc),
        .last   (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: IDLE -> CALC on start, CALC -> FIX after the last iteration, FIX -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CALC;
            ST_CALC: if (last)  state_nxt = ST_FIX;
            ST_FIX:             state_nxt = ST_IDLE;
            default:            state_nxt = ST_IDLE;
        endcase
    end

    // Sign correction of the magnitude result; divide by zero forces HI=A, LO=all ones.
    always_comb begin
        q_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
        sa       = q_signed && a_q[WIDTH-1];
        sb       = q_signed && b_q[WIDTH-1];
        prod     = (sa ^ sb) ? (~acc + 1'b1) : acc;
        if (!op_q[1]) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (b_q == '0) begin
            res_hi = a_q;
            res_lo = '1;
        end else begin
            res_hi = sa        ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
            res_lo = (sa ^ sb) ? (~acc[WIDTH-1:0] + 1'b1)       : acc[WIDTH-1:0];
        end
    end

    // Output next values: direct writes only in IDLE without start, results in FIX.
    always_comb begin
        hi_d   = hi;
        lo_d   = lo;
        done_d = 1'b0;
        busy_d = (state_nxt != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (!start) begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            ST_FIX: begin
                hi_d   = res_hi;
                lo_d   = res_lo;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs and operands latched at the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            op_q <= OP_MULT;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            hi   <= hi_d;
            lo   <= lo_d;
            busy <= busy_d;
            done <= done_d;
            if (load) begin
                op_q <= op_t'(op);
                a_q  <= busA;
                b_q  <= busB;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Every wait is a fixed number of cycles, so the run always terminates.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] busA, busB, wdata;
    logic        hi_we, lo_we;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks   = 0;
    int failures = 0;
    bit disturb        = 1'b0;
    bit we_with_start  = 1'b0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .busA  (busA),
        .busB  (busB),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start an operation at the next rising edge (E0) and follow it to the done cycle (E33).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
        logic [31:0] h0, l0;
        int bad;
        h0 = hi;
        l0 = lo;
        op = o; busA = a; busB = b; start = 1'b1;
        if (we_with_start) begin
            lo_we = 1'b1;
            wdata = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done_e0"}, {31'd0, done}, 32'd0);
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            if (disturb && i == 5) busA = 32'h7777_0000;
            if (disturb && i == 10) begin
                start = 1'b1; op = 2'b10; hi_we = 1'b1; wdata = 32'hBAD0_BAD0;
            end
            if (disturb && i == 11) begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0 || hi !== h0 || lo !== l0) bad++;
        end
        chk({tag, "_busy_hold_bad_cycles"}, bad, 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int stray;
        rst_n = 1'b1; start = 1'b0; op = 2'b00; busA = '0; busB = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Consecutive calls start in the done cycle of the previous op (back-to-back).
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minxmin");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
        run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2");
        run_op(2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, "divu_by0");
        run_op(2'b10, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF, "div_neg_by0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow");
        run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001, "divu_bigdiv");

        // Operand change at E5 and start+hi_we at E10 must have no effect.
        disturb = 1'b1;
        run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, "multu_disturbed");
        disturb = 1'b0;
        busA = '0;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        // Abort a DIVU with reset at E15.
        op = 2'b11; busA = 32'd1000; busB = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        chk("abort_no_done", stray, 32'd0);
        run_op(2'b11, 32'd9, 32'd4, 32'd1, 32'd2, "divu_after_reset");
        @(negedge clk);

        // Direct HI/LO writes in IDLE.
        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'h0000_1234);
        chk("mthi_lo_kept", lo, 32'd2);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_5678;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthilo_hi", hi, 32'h0000_5678);
        chk("mthilo_lo", lo, 32'h0000_5678);

        // start wins over lo_we in the same cycle.
        we_with_start = 1'b1;
        run_op(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, "start_over_lowe");
        we_with_start = 1'b0;
        @(negedge clk);
        chk("final_done_low", {31'd0, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
